// File: rtl/error_inject_ctrl.sv
// Bit-flip injection controller for the codeword path ahead of the Hamming decoder.
// Two debounced buttons each request a fixed bit flip; an optional auto mode sweeps a
// single flipped bit across the word. Each injection is presented for exactly one
// accepted upstream word, followed by a lockout period.
module error_inject_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned BIT_A       = 0,
  parameter int unsigned BIT_B       = 4,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              btn1,
  input  logic              btn2,
  input  logic              auto_en,
  input  logic              word_valid,
  output logic [DATA_W-1:0] flip_mask,
  output logic              mask_valid,
  output logic              busy,
  output logic [7:0]        inj_count
);

  localparam int unsigned DebW  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PtrW  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StArm, StHold} state_e;

  // Index 0 is btn1, index 1 is btn2.
  logic [1:0]           btn_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           deb_q, deb_d, deb_prev_q;
  logic [1:0][DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]           pend_q, pend_d, pend_clr;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [7:0]          inj_cnt_q, inj_cnt_d;

  logic [DATA_W-1:0]   flip_mask_q, flip_mask_d;
  logic                mask_valid_q, mask_valid_d;
  logic                busy_q, busy_d;

  assign btn_raw = {btn2, btn1};

  // Two-flop synchronizers plus the previous debounced level for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
      pend_q     <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      pend_q     <= pend_d;
    end
  end

  // Debounce: a new level is accepted after DEB_CYCLES consecutive differing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
    // Sticky requests: captured flags clear on arm, a fresh rising edge always wins.
    pend_d = (pend_q & ~pend_clr) | (deb_q & ~deb_prev_q);
  end

  // State register for the injection FSM and its datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      inj_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      inj_cnt_q  <= inj_cnt_d;
    end
  end

  // Next-state logic: buttons take priority over the auto sweep.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    inj_cnt_d  = inj_cnt_q;
    pend_clr   = '0;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StArm;
          mask_d  = '0;
          if (pend_q[0]) mask_d[BIT_A] = 1'b1;
          if (pend_q[1]) mask_d[BIT_B] = 1'b1;
          pend_clr = pend_q;
        end else if (auto_en) begin
          state_d = StArm;
          mask_d  = DATA_W'(1) << ptr_q;
          ptr_d   = (ptr_q == PtrW'(DATA_W - 1)) ? '0 : ptr_q + 1'b1;
        end
      end
      StArm: begin
        if (word_valid) begin
          state_d    = StHold;
          hold_cnt_d = '0;
          if (inj_cnt_q != 8'hFF) inj_cnt_d = inj_cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so the outputs are registered yet cycle-aligned.
  always_comb begin
    mask_valid_d = (state_d == StArm);
    flip_mask_d  = mask_valid_d ? mask_d : '0;
    busy_d       = (state_d != StIdle);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flip_mask_q  <= '0;
      mask_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      flip_mask_q  <= flip_mask_d;
      mask_valid_q <= mask_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign flip_mask  = flip_mask_q;
  assign mask_valid = mask_valid_q;
  assign busy       = busy_q;
  assign inj_count  = inj_cnt_q;

endmodule

// File: tb/tb_error_inject_ctrl.sv
// Directed bench for error_inject_ctrl: a vector table of button presses plus
// hand-written sequences for reset, stalls, the auto sweep and counter saturation.
module tb_error_inject_ctrl;

  logic       clk;
  logic       rstn;
  logic       btn1;
  logic       btn2;
  logic       auto_en;
  logic       word_valid;
  logic [7:0] flip_mask;
  logic       mask_valid;
  logic       busy;
  logic [7:0] inj_count;

  int checks   = 0;
  int failures = 0;
  int exp_inj  = 0;

  logic [7:0] cons[$];

  typedef struct {
    string      name;
    logic       b1;
    logic       b2;
    int         press;
    int         exp_events;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t vecs[6];

  error_inject_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn1       (btn1),
    .btn2       (btn2),
    .auto_en    (auto_en),
    .word_valid (word_valid),
    .flip_mask  (flip_mask),
    .mask_valid (mask_valid),
    .busy       (busy),
    .inj_count  (inj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every mask the datapath would consume.
  always @(negedge clk) begin
    if (rstn && mask_valid && word_valid) cons.push_back(flip_mask);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the given buttons high for n sampling edges, then release.
  task automatic press(input logic b1, input logic b2, input int n);
    @(posedge clk);
    #1;
    btn1 = b1;
    btn2 = b2;
    repeat (n) @(posedge clk);
    #1;
    btn1 = 1'b0;
    btn2 = 1'b0;
  endtask

  task automatic wait_mv(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (mask_valid) ok = 1'b1;
    end
  endtask

  initial begin
    bit         ok;
    int         n0;
    int         bad;
    logic [7:0] exp_seq[10];

    vecs[0] = '{"btn1_press",    1'b1, 1'b0, 21, 1, 8'h01};
    vecs[1] = '{"btn1_glitch",   1'b1, 1'b0, 14, 0, 8'h00};
    vecs[2] = '{"btn1_short15",  1'b1, 1'b0, 15, 0, 8'h00};
    vecs[3] = '{"btn1_exact16",  1'b1, 1'b0, 16, 1, 8'h01};
    vecs[4] = '{"btn_both",      1'b1, 1'b1, 21, 1, 8'h11};
    vecs[5] = '{"btn2_press",    1'b0, 1'b1, 21, 1, 8'h10};

    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    // Power-on reset.
    rstn = 1'b0; btn1 = 1'b0; btn2 = 1'b0; auto_en = 1'b0; word_valid = 1'b0;
    #3;
    chk("rst_flip_mask", flip_mask, 8'h00);
    chk("rst_mask_valid", mask_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_inj_count", inj_count, 8'h00);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset while armed abandons the injection.
    press(1'b1, 1'b0, 21);
    wait_mv(40, ok);
    chk("midarm_armed", ok, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midarm_flip_mask", flip_mask, 8'h00);
    chk("midarm_mask_valid", mask_valid, 1'b0);
    chk("midarm_busy", busy, 1'b0);
    chk("midarm_inj_count", inj_count, 8'h00);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b1;
    n0 = cons.size();
    repeat (40) @(posedge clk);
    chk("midarm_no_mask_after", cons.size() - n0, 0);
    chk("midarm_inj_after", inj_count, 8'h00);

    // Table of button presses with word_valid held high.
    for (int v = 0; v < 6; v++) begin
      n0 = cons.size();
      press(vecs[v].b1, vecs[v].b2, vecs[v].press);
      repeat (60) @(posedge clk);
      exp_inj += vecs[v].exp_events;
      @(negedge clk);
      chk({vecs[v].name, "_events"}, cons.size() - n0, vecs[v].exp_events);
      if (vecs[v].exp_events > 0 && cons.size() > n0)
        chk({vecs[v].name, "_mask"}, cons[n0], vecs[v].exp_mask);
      chk({vecs[v].name, "_inj"}, inj_count, exp_inj);
      chk({vecs[v].name, "_busy"}, busy, 1'b0);
    end

    // Stall: btn2 armed with no upstream word for 50 cycles.
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    n0 = cons.size();
    press(1'b0, 1'b1, 21);
    wait_mv(40, ok);
    chk("stall_armed", ok, 1'b1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(mask_valid && flip_mask == 8'h10 && busy)) bad++;
    end
    chk("stall_stable", bad, 0);
    @(posedge clk);
    #1;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    exp_inj++;
    chk("stall_consumed", cons.size() - n0, 1);
    if (cons.size() > n0) chk("stall_mask", cons[n0], 8'h10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold_busy", busy, 1'b1);
      chk("stall_hold_mask_valid", mask_valid, 1'b0);
    end
    @(negedge clk);
    chk("stall_idle_busy", busy, 1'b0);
    chk("stall_inj", inj_count, exp_inj);

    // Auto sweep with a btn2 press landing mid-sweep.
    repeat (5) @(posedge clk);
    #1;
    n0 = cons.size();
    auto_en    = 1'b1;
    word_valid = 1'b1;
    repeat (2) @(posedge clk);
    press(1'b0, 1'b1, 21);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (cons.size() - n0 >= 10) ok = 1'b1;
    end
    #1;
    auto_en = 1'b0;
    chk("auto_ten_rounds", ok, 1'b1);
    repeat (20) @(posedge clk);
    chk("auto_round_count", cons.size() - n0, 10);
    for (int i = 0; i < 10; i++) begin
      if (cons.size() > n0 + i) chk($sformatf("auto_seq_%0d", i), cons[n0 + i], exp_seq[i]);
    end
    exp_inj += 10;
    chk("auto_inj", inj_count, exp_inj);

    // Dropping auto_en while armed still completes the injection (ptr is now 1).
    #1;
    word_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n0 = cons.size();
    auto_en = 1'b1;
    wait_mv(20, ok);
    chk("drop_armed", ok, 1'b1);
    @(posedge clk);
    #1;
    auto_en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drop_still_valid", mask_valid, 1'b1);
    chk("drop_mask", flip_mask, 8'h02);
    @(posedge clk);
    #1;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    exp_inj++;
    repeat (10) @(posedge clk);
    chk("drop_consumed", cons.size() - n0, 1);
    chk("drop_inj", inj_count, exp_inj);

    // Saturation of the injection counter.
    #1;
    auto_en    = 1'b1;
    word_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      if (inj_count == 8'hFF) ok = 1'b1;
    end
    chk("sat_reached", ok, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    auto_en = 1'b0;
    repeat (10) @(posedge clk);
    chk("sat_hold", inj_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
